// File: rtl/music_player_pkg.sv
// Shared types and constants for the music player: FSM states, ROM entry layout,
// and tone half-periods in 100 MHz clock cycles.
package music_player_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StLoad,
      StPlay,
      StPause,
      StDone
   } state_e;

   localparam int unsigned NoteW = 5;
   localparam int unsigned DurW  = 3;
   localparam int unsigned AddrW = 7;
   localparam int unsigned SongW = 2;
   localparam int unsigned HalfW = 18;

   localparam logic [NoteW-1:0] NOTE_REST = 5'd0;
   localparam logic [NoteW-1:0] NOTE_END  = 5'd31;

   // Index 0 is rest, 1..30 are chromatic pitches upward from C4, 31 is the end marker.
   localparam logic [HalfW-1:0] HALF_PERIOD [32] = '{
      18'd0,
      18'd191113, 18'd180388, 18'd170262, 18'd160705, 18'd151686, 18'd143173,
      18'd135137, 18'd127553, 18'd120394, 18'd113636, 18'd107259, 18'd101239,
      18'd95556,  18'd90194,  18'd85131,  18'd80353,  18'd75843,  18'd71586,
      18'd67569,  18'd63776,  18'd60197,  18'd56818,  18'd53629,  18'd50619,
      18'd47778,  18'd45097,  18'd42566,  18'd40177,  18'd37922,  18'd35793,
      18'd0
   };

endpackage

// File: rtl/music_player_song_rom.sv
// Synchronous 512x8 song ROM, four songs of 128 {note, dur} entries each.
module song_rom
   import music_player_pkg::*;
(
   input  logic       clk_i,
   input  logic [8:0] addr_i,
   output logic [7:0] data_o
);

   function automatic logic [7:0] rom_entry(input logic [8:0] a);
      logic [6:0] idx;
      logic [6:0] rem;
      idx = a[6:0];
      rem = idx % 7'd30;
      rom_entry = {NOTE_END, 3'd0};
      unique case (a[8:7])
         2'd0: begin
            if (idx == 7'd0)      rom_entry = {5'd5, 3'd1};
            else if (idx == 7'd1) rom_entry = {NOTE_REST, 3'd0};
         end
         2'd1: begin
            if (idx == 7'd0)      rom_entry = {5'd1, 3'd2};
            else if (idx == 7'd1) rom_entry = {5'd3, 3'd2};
            else if (idx == 7'd2) rom_entry = {5'd5, 3'd3};
         end
         2'd2: begin
            if (idx == 7'd0)      rom_entry = {5'd10, 3'd0};
            else if (idx == 7'd1) rom_entry = {5'd12, 3'd0};
         end
         // Song 3 fills all 128 slots with pitches and never reaches a marker.
         default: rom_entry = {rem[4:0] + 5'd1, 3'd0};
      endcase
   endfunction

   always_ff @(posedge clk_i) begin
      data_o <= rom_entry(addr_i);
   end

endmodule

// File: rtl/music_player.sv
// Playback engine: walks a song's note table, drives a square wave per note
// for its beat count, and pulses song_done at the end marker.
module music_player
   import music_player_pkg::*;
#(
   parameter int unsigned BEAT_CYCLES = 12_500_000,
   parameter int unsigned DIV_SHIFT   = 0
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             play_i,
   input  logic             reset_play_i,
   input  logic [SongW-1:0] song_i,
   output logic             song_done_o,
   output logic             audio_o,
   output logic [NoteW-1:0] note_o
);

   state_e           state_q, state_d;
   logic [AddrW-1:0] addr_q, addr_d;
   logic [SongW-1:0] song_q, song_d;
   logic [NoteW-1:0] cur_note_q, cur_note_d, note_q, note_d;
   logic [DurW-1:0]  beats_q, beats_d;
   logic [31:0]      presc_q, presc_d;
   logic [HalfW-1:0] tone_q, tone_d, half_raw, half;
   logic             phase_q, phase_d, audio_q, audio_d, done_q, done_d;
   logic [7:0]       rom_data;
   logic [NoteW-1:0] rom_note;
   logic [DurW-1:0]  rom_dur;
   logic             beat_end, last_beat, tone_wrap;

   song_rom u_rom (
      .clk_i  (clk_i),
      .addr_i ({song_q, addr_q}),
      .data_o (rom_data)
   );

   assign rom_note  = rom_data[7:3];
   assign rom_dur   = rom_data[2:0];
   assign half_raw  = HALF_PERIOD[cur_note_q] >> DIV_SHIFT;
   assign half      = (half_raw == '0) ? HalfW'(1) : half_raw;
   assign tone_wrap = (tone_q == half - HalfW'(1));
   assign beat_end  = (presc_q == BEAT_CYCLES - 1);
   assign last_beat = beat_end && (beats_q == '0);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      song_d     = song_q;
      cur_note_d = cur_note_q;
      beats_d    = beats_q;
      presc_d    = presc_q;
      tone_d     = tone_q;
      phase_d    = phase_q;
      note_d     = note_q;
      audio_d    = audio_q;
      done_d     = 1'b0;
      if (reset_play_i) begin
         state_d    = StIdle;
         song_d     = song_i;
         addr_d     = '0;
         cur_note_d = NOTE_REST;
         beats_d    = '0;
         presc_d    = '0;
         tone_d     = '0;
         phase_d    = 1'b0;
         note_d     = NOTE_REST;
         audio_d    = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               addr_d  = '0;
               note_d  = NOTE_REST;
               audio_d = 1'b0;
               if (play_i) state_d = StFetch;
            end
            StFetch: state_d = StLoad;
            StLoad: begin
               note_d  = NOTE_REST;
               audio_d = 1'b0;
               if (rom_note == NOTE_END) begin
                  done_d  = 1'b1;
                  state_d = StDone;
               end else begin
                  cur_note_d = rom_note;
                  note_d     = rom_note;
                  beats_d    = rom_dur;
                  presc_d    = '0;
                  tone_d     = '0;
                  phase_d    = 1'b0;
                  state_d    = StPlay;
               end
            end
            StPlay: begin
               presc_d = beat_end ? '0 : presc_q + 32'd1;
               if (beat_end) beats_d = beats_q - DurW'(1);
               if (cur_note_q == NOTE_REST) begin
                  tone_d  = '0;
                  phase_d = 1'b0;
               end else if (tone_wrap) begin
                  tone_d  = '0;
                  phase_d = ~phase_q;
               end else begin
                  tone_d = tone_q + HalfW'(1);
               end
               audio_d = phase_d;
               if (last_beat) begin
                  note_d  = NOTE_REST;
                  audio_d = 1'b0;
                  presc_d = '0;
                  beats_d = '0;
                  tone_d  = '0;
                  phase_d = 1'b0;
                  // The last table slot ends the song instead of wrapping to entry 0.
                  if (addr_q == '1) begin
                     done_d  = 1'b1;
                     state_d = StDone;
                  end else begin
                     addr_d  = addr_q + AddrW'(1);
                     state_d = StFetch;
                  end
               end else if (!play_i) begin
                  note_d  = NOTE_REST;
                  audio_d = 1'b0;
                  state_d = StPause;
               end
            end
            StPause: begin
               if (play_i) begin
                  note_d  = cur_note_q;
                  audio_d = phase_q;
                  state_d = StPlay;
               end
            end
            StDone: begin
               note_d  = NOTE_REST;
               audio_d = 1'b0;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         song_q     <= '0;
         cur_note_q <= NOTE_REST;
         beats_q    <= '0;
         presc_q    <= '0;
         tone_q     <= '0;
         phase_q    <= 1'b0;
         note_q     <= NOTE_REST;
         audio_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         song_q     <= song_d;
         cur_note_q <= cur_note_d;
         beats_q    <= beats_d;
         presc_q    <= presc_d;
         tone_q     <= tone_d;
         phase_q    <= phase_d;
         note_q     <= note_d;
         audio_q    <= audio_d;
         done_q     <= done_d;
      end
   end

   assign song_done_o = done_q;
   assign audio_o     = audio_q;
   assign note_o      = note_q;

endmodule

// File: tb/tb_music_player.sv
// Directed bench for music_player with 4-cycle beats and a 16-bit tone shift
// so that note 5 has half-period 2 and notes 10/12 have half-period 1.
module tb_music_player;

   logic       clk;
   logic       reset_n;
   logic       play;
   logic       reset_play;
   logic [1:0] song;
   logic       song_done;
   logic       audio;
   logic [4:0] note;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       play;
      logic       rp;
      logic [1:0] song;
      logic [4:0] note;
      logic       audio;
      logic       done;
   } vec_t;

   vec_t vecs[$];

   music_player #(
      .BEAT_CYCLES (4),
      .DIV_SHIFT   (16)
   ) dut (
      .clk_i        (clk),
      .reset_ni     (reset_n),
      .play_i       (play),
      .reset_play_i (reset_play),
      .song_i       (song),
      .song_done_o  (song_done),
      .audio_o      (audio),
      .note_o       (note)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic add(input logic p, input logic r, input logic [1:0] s, input logic [4:0] n,
                      input logic a, input logic d);
      vec_t v;
      v.play = p; v.rp = r; v.song = s; v.note = n; v.audio = a; v.done = d;
      vecs.push_back(v);
   endtask

   task automatic restart(input logic [1:0] s);
      reset_play = 1'b1;
      song       = s;
      play       = 1'b0;
      tick();
      reset_play = 1'b0;
   endtask

   initial begin
      int n5, paused_bad, done_cnt, done_at, stray;

      // Song 0 from reset: note 5 (2 beats), gap, rest (1 beat), gap, end pulse.
      add(1,0,0, 0,0,0); add(1,0,0, 0,0,0);
      add(1,0,0, 5,0,0); add(1,0,0, 5,0,0); add(1,0,0, 5,1,0); add(1,0,0, 5,1,0);
      add(1,0,0, 5,0,0); add(1,0,0, 5,0,0); add(1,0,0, 5,1,0); add(1,0,0, 5,1,0);
      add(1,0,0, 0,0,0); add(1,0,0, 0,0,0);
      add(1,0,0, 0,0,0); add(1,0,0, 0,0,0); add(1,0,0, 0,0,0); add(1,0,0, 0,0,0);
      add(1,0,0, 0,0,0); add(1,0,0, 0,0,0); add(1,0,0, 0,0,1); add(1,0,0, 0,0,0);
      add(1,0,0, 0,0,0);
      // Restart onto song 2, then restart it again mid-note with song 0 on the bus afterwards.
      add(0,1,2, 0,0,0); add(1,0,2, 0,0,0); add(1,0,2, 0,0,0);
      add(1,0,2, 10,0,0); add(1,0,2, 10,1,0); add(1,0,2, 10,0,0); add(1,0,2, 10,1,0);
      add(1,0,2, 0,0,0); add(1,0,2, 0,0,0); add(1,0,2, 12,0,0);
      add(1,1,2, 0,0,0); add(1,0,0, 0,0,0); add(1,0,0, 0,0,0); add(1,0,0, 10,0,0);

      reset_n    = 1'b0;
      play       = 1'b0;
      reset_play = 1'b0;
      song       = 2'd0;
      tick();
      tick();
      chk("reset_note", int'(note), 0);
      chk("reset_audio", int'(audio), 0);
      chk("reset_done", int'(song_done), 0);
      reset_n = 1'b1;

      foreach (vecs[i]) begin
         play       = vecs[i].play;
         reset_play = vecs[i].rp;
         song       = vecs[i].song;
         tick();
         chk($sformatf("vec%0d_note", i), int'(note), int'(vecs[i].note));
         chk($sformatf("vec%0d_audio", i), int'(audio), int'(vecs[i].audio));
         chk($sformatf("vec%0d_done", i), int'(song_done), int'(vecs[i].done));
      end

      // Pause mid-note: counters freeze, note 5 still shows for exactly 8 cycles.
      restart(2'd0);
      play = 1'b1;
      n5 = 0; paused_bad = 0; done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (note == 5'd5) n5++;
      end
      play = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (audio !== 1'b0 || note !== 5'd0) paused_bad++;
      end
      play = 1'b1;
      tick();
      if (note == 5'd5) n5++;
      chk("pause_resume_audio", int'(audio), 1);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (note == 5'd5) n5++;
         if (song_done) done_cnt++;
      end
      chk("pause_silent", paused_bad, 0);
      chk("pause_note5_cycles", n5, 8);
      chk("pause_done_pulses", done_cnt, 1);

      // reset_play during LOAD of the end marker suppresses the pulse.
      restart(2'd0);
      play = 1'b1;
      for (int i = 0; i < 18; i++) tick();
      reset_play = 1'b1;
      tick();
      chk("rp_vs_end_done", int'(song_done), 0);
      chk("rp_vs_end_note", int'(note), 0);
      reset_play = 1'b0;
      play       = 1'b0;
      done_cnt   = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (song_done) done_cnt++;
      end
      chk("rp_vs_end_nopulse", done_cnt, 0);
      play = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("rp_vs_end_idle_restart", int'(note), 5);

      // Song 3 runs all 128 entries and ends without wrapping.
      restart(2'd3);
      play = 1'b1;
      done_cnt = 0; done_at = -1;
      for (int i = 1; i <= 800; i++) begin
         tick();
         if (i == 3) chk("song3_first_note", int'(note), 1);
         if (i == 765) chk("song3_last_note", int'(note), 8);
         if (song_done) begin
            done_cnt++;
            if (done_at < 0) done_at = i;
         end
      end
      chk("song3_done_cycle", done_at, 769);
      chk("song3_done_pulses", done_cnt, 1);
      stray = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (note !== 5'd0 || song_done !== 1'b0 || audio !== 1'b0) stray++;
      end
      chk("song3_done_holds", stray, 0);

      // Hard reset mid-note clears outputs and returns to song 0.
      restart(2'd2);
      play = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("hreset_pre_audio", int'(audio), 1);
      reset_n = 1'b0;
      tick();
      chk("hreset_note", int'(note), 0);
      chk("hreset_audio", int'(audio), 0);
      chk("hreset_done", int'(song_done), 0);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("hreset_song0_note", int'(note), 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
